// File: rtl/fp_argmax_classifier.sv
// FP16 argmax stage behind the MLP output layer.
// Scans one packed vector element-per-cycle and reports the winning class.
module fp_argmax_classifier #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CLASSES  = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH*N_CLASSES-1:0] in_vec,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [IDX_WIDTH-1:0]            out_class,
    output logic [DATA_WIDTH-1:0]           out_max,
    output logic                            out_nan
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic [DATA_WIDTH*N_CLASSES-1:0] r_vec;
    logic [DATA_WIDTH-1:0]           r_best;
    logic [IDX_WIDTH-1:0]            r_best_idx;
    logic                            r_nan;
    logic [IDX_WIDTH-1:0]            r_cnt;
    logic                            r_out_valid;
    logic [IDX_WIDTH-1:0]            r_out_class;
    logic [DATA_WIDTH-1:0]           r_out_max;
    logic                            r_out_nan;

    logic [DATA_WIDTH-1:0]           w_cand;
    logic                            w_upd;
    logic                            w_last;
    logic                            w_nan_next;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Ordered compare: NaN sorts below everything, +0 == -0.
    function automatic logic fp_gt(input logic [15:0] c, input logic [15:0] b);
        logic res;
        if (is_nan(c))
            res = 1'b0;
        else if (is_nan(b))
            res = 1'b1;
        else if ((c[14:0] == 15'd0) && (b[14:0] == 15'd0))
            res = 1'b0;
        else if (c[15] != b[15])
            res = ~c[15];
        else if (!c[15])
            res = c[14:0] > b[14:0];
        else
            res = c[14:0] < b[14:0];
        return res;
    endfunction

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (r_cnt == i[IDX_WIDTH-1:0])
                w_cand = r_vec[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_upd      = fp_gt(w_cand, r_best);
    assign w_nan_next = r_nan | is_nan(w_cand);
    assign w_last     = (r_cnt == IDX_WIDTH'(N_CLASSES - 1));

    assign in_ready  = (r_state == IDLE) && rst;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_max   = r_out_max;
    assign out_nan   = r_out_nan;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_nan       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_max   <= '0;
            r_out_nan   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vec      <= in_vec;
                        r_best     <= in_vec[DATA_WIDTH-1:0];
                        r_best_idx <= '0;
                        r_nan      <= is_nan(in_vec[DATA_WIDTH-1:0]);
                        r_cnt      <= IDX_WIDTH'(1);
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_nan <= w_nan_next;
                    if (w_upd) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_cnt;
                    end
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_class <= w_upd ? r_cnt : r_best_idx;
                        r_out_max   <= w_upd ? w_cand : r_best;
                        r_out_nan   <= w_nan_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_argmax_classifier.sv
// Self-checking bench for fp_argmax_classifier.
// Reference model orders elements by their real-number value.
module tb_fp_argmax_classifier;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_class;
    logic [15:0] out_max;
    logic        out_nan;

    int n_checks = 0;
    int n_fail   = 0;

    fp_argmax_classifier #(
        .DATA_WIDTH(16),
        .N_CLASSES (4),
        .IDX_WIDTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_max  (out_max),
        .out_nan  (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic bit m_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    endfunction

    function automatic real m_value(input logic [15:0] x);
        real mag;
        int  e;
        e = int'(x[14:10]);
        if (e == 31) begin
            mag = 1.0e30;
        end else if (e == 0) begin
            mag = real'(x[9:0]) / 16777216.0;
        end else begin
            mag = real'(1024 + int'(x[9:0])) / 16777216.0;
            for (int k = 1; k < e; k++) mag = mag * 2.0;
        end
        return x[15] ? -mag : mag;
    endfunction

    task automatic model(input logic [63:0] v, output logic [1:0] cls,
                         output logic [15:0] mx, output logic nan);
        int  best;
        real bv;
        logic [15:0] el [4];
        for (int i = 0; i < 4; i++) el[i] = v[i*16 +: 16];
        best = -1;
        bv   = 0.0;
        nan  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_is_nan(el[i])) begin
                nan = 1'b1;
            end else if (best < 0 || m_value(el[i]) > bv) begin
                best = i;
                bv   = m_value(el[i]);
            end
        end
        if (best < 0) best = 0;
        cls = best[1:0];
        mx  = el[best];
    endtask

    // Offers v, waits for the accept edge, then waits for out_valid.
    task automatic xact(input logic [63:0] v, output logic [1:0] cls,
                        output logic [15:0] mx, output logic nan, output int lat);
        int k;
        in_vec   = v;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        cls = out_class;
        mx  = out_max;
        nan = out_nan;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_vec = '0;
        #2;
        n_checks++;
        if ({out_valid, out_class, out_max, out_nan, in_ready} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%0d m=%h n=%b rdy=%b want all 0",
                     out_valid, out_class, out_max, out_nan, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [63:0] vecs [6];
        logic [1:0]  ecls [6];
        logic [15:0] emax [6];
        logic        enan [6];
        logic [1:0]  c;
        logic [15:0] m;
        logic        n;
        int          lat;
        vecs[0] = pack4(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
        vecs[1] = pack4(16'hC000, 16'hBC00, 16'hC200, 16'hC400);
        vecs[2] = pack4(16'h8000, 16'h0000, 16'h8000, 16'h0000);
        vecs[3] = pack4(16'h3C00, 16'h3C00, 16'h3800, 16'h3C00);
        vecs[4] = pack4(16'h7E00, 16'hBC00, 16'h7C00, 16'h7E01);
        vecs[5] = pack4(16'h7E00, 16'hFE00, 16'h7C01, 16'h7FFF);
        ecls = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};
        emax = '{16'h4000, 16'hBC00, 16'h8000, 16'h3C00, 16'h7C00, 16'h7E00};
        enan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            xact(vecs[i], c, m, n, lat);
            n_checks++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
            end
            n_checks++;
            if ({c, m, n} !== {ecls[i], emax[i], enan[i]}) begin
                n_fail++;
                $display("FAIL dir%0d_result: got c=%0d m=%h n=%b want c=%0d m=%h n=%b",
                         i, c, m, n, ecls[i], emax[i], enan[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_one_cycle: got v=%b rdy=%b want v=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    function automatic logic [15:0] rnd_elem();
        logic [15:0] pool [8];
        pool = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                 16'h7E00, 16'h0001, 16'h8001, 16'h3C00};
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    task automatic test_random;
        logic [63:0] v;
        logic [1:0]  c, ec;
        logic [15:0] m, em;
        logic        n, en;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            v = {rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()};
            if ($urandom_range(0, 4) == 0) v[31:16] = v[15:0];
            model(v, ec, em, en);
            xact(v, c, m, n, lat);
            n_checks++;
            if (lat !== 3 || {c, m, n} !== {ec, em, en}) begin
                n_fail++;
                $display("FAIL rand%0d vec=%h: got c=%0d m=%h n=%b lat=%0d want c=%0d m=%h n=%b lat=3",
                         i, v, c, m, n, lat, ec, em, en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] v1, v2;
        logic [1:0]  c, ec;
        logic [15:0] m, em;
        logic        n, en;
        int          lat;
        v1 = pack4(16'h4400, 16'hC000, 16'h3C00, 16'h4200);
        v2 = pack4(16'h3800, 16'hBC00, 16'h4500, 16'h3C00);
        out_ready = 1'b0;
        xact(v1, c, m, n, lat);
        n_checks++;
        if (lat !== 3 || {c, m, n} !== {2'd0, 16'h4400, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_first: got c=%0d m=%h n=%b lat=%0d want c=0 m=4400 n=0 lat=3",
                     c, m, n, lat);
        end
        in_vec   = v2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_class, out_max, out_nan} !== {2'd0, 16'h4400, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b c=%0d m=%h want v=1 rdy=0 c=0 m=4400",
                         i, out_valid, in_ready, out_class, out_max);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        model(v2, ec, em, en);
        xact(v2, c, m, n, lat);
        n_checks++;
        if (lat !== 3 || {c, m, n} !== {ec, em, en}) begin
            n_fail++;
            $display("FAIL bp_next: got c=%0d m=%h n=%b lat=%0d want c=%0d m=%h n=%b lat=3",
                     c, m, n, lat, ec, em, en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midscan;
        logic [1:0]  c;
        logic [15:0] m;
        logic        n;
        int          lat;
        out_ready = 1'b1;
        in_vec   = pack4(16'h7C00, 16'h7E00, 16'h5000, 16'h4000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_class, out_max, out_nan} !== 21'd0) begin
            n_fail++;
            $display("FAIL midscan_reset: got v=%b rdy=%b c=%0d m=%h n=%b want all 0",
                     out_valid, in_ready, out_class, out_max, out_nan);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_no_result: got v=%b want 0", out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_ready: got %b want 1", in_ready);
        end
        xact(pack4(16'h3800, 16'h3C00, 16'h4000, 16'h4200), c, m, n, lat);
        n_checks++;
        if (lat !== 3 || {c, m, n} !== {2'd3, 16'h4200, 1'b0}) begin
            n_fail++;
            $display("FAIL midscan_next: got c=%0d m=%h n=%b lat=%0d want c=3 m=4200 n=0 lat=3",
                     c, m, n, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
